// File: rtl/note_recorder.sv
`default_nettype none
// ============================================================================
//  Module   : note_recorder
//  Purpose  : Captures live keyboard notes and writes {note, duration} words
//             to the song memory through a valid/ready write port.
//  Option   : RECORDER_TAIL_MARK_EN appends an all-ones end-of-song marker.
//  Revision : 1.0  initial release
// ============================================================================
module note_recorder #(
   parameter int NOTE_W = 5,
   parameter int DUR_W  = 4,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rec_start,
   input  logic                      rec_stop,
   input  logic                      tick,
   input  logic [NOTE_W-1:0]         note_in,
   input  logic                      wr_ready,
   output logic                      wr_en,
   output logic [NOTE_W+DUR_W-1:0]   wr_data,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [ADDR_W:0]           length,
   output logic                      recording,
   output logic                      full,
   output logic                      overrun,
   output logic                      done
);

   localparam int WORD_W = NOTE_W + DUR_W;
`ifdef RECORDER_TAIL_MARK_EN
   localparam logic c_tail_en    = 1'b1;
   localparam int   c_cap_words  = DEPTH - 1;
`else
   localparam logic c_tail_en    = 1'b0;
   localparam int   c_cap_words  = DEPTH;
`endif
   localparam logic [DUR_W-1:0]  c_dur_max = '1;
   localparam logic [ADDR_W+1:0] c_cap     = (ADDR_W+2)'(c_cap_words);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_CAPTURE = 3'd2,
      S_DRAIN   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [DUR_W-1:0]    dur_q, dur_d;
   logic                pend_vld_q, pend_vld_d;
   logic [WORD_W-1:0]   pend_data_q, pend_data_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic                full_q, full_d;
   logic                ovr_q, ovr_d;
   logic                mark_q, mark_d;

   logic                w_accept;
   logic                w_buf_free;
   logic [DUR_W-1:0]    w_dur_fin;
   logic                w_seg_vld;
   logic [WORD_W-1:0]   w_seg_word;
   logic                w_end_cap;
   logic [ADDR_W+1:0]   w_occ_next;
   logic                w_cap_hit;

   assign w_accept   = pend_vld_q && wr_ready;
   assign w_buf_free = !pend_vld_q || w_accept;
   // A tick arriving in the cycle a segment ends still belongs to that segment.
   assign w_dur_fin  = (tick && (dur_q != c_dur_max)) ? dur_q + DUR_W'(1) : dur_q;
   // Accepted plus pending words is invariant under acceptance, so this is the
   // occupancy once the new segment lands in the (free) buffer.
   assign w_occ_next = {1'b0, len_q} + (ADDR_W+2)'(pend_vld_q) + (ADDR_W+2)'(1);
   assign w_cap_hit  = (w_occ_next >= c_cap);

   always_comb begin
      state_d     = state_q;
      note_d      = note_q;
      dur_d       = dur_q;
      pend_vld_d  = pend_vld_q;
      pend_data_d = pend_data_q;
      addr_d      = addr_q;
      len_d       = len_q;
      full_d      = full_q;
      ovr_d       = ovr_q;
      mark_d      = mark_q;
      w_seg_vld   = 1'b0;
      w_seg_word  = {note_q, w_dur_fin};
      w_end_cap   = 1'b0;

      if (w_accept) begin
         pend_vld_d = 1'b0;
         addr_d     = addr_q + ADDR_W'(1);
         len_d      = len_q + (ADDR_W+1)'(1);
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (rec_start && !rec_stop) begin
               state_d = S_ARMED;
               addr_d  = '0;
               len_d   = '0;
               full_d  = 1'b0;
               ovr_d   = 1'b0;
            end
         end
         S_ARMED: begin
            if (rec_stop) begin
               state_d = S_DONE;
            end else if (note_in != '0) begin
               note_d  = note_in;
               dur_d   = '0;
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (rec_stop) begin
               // Trailing rests and zero-length tails are not stored.
               w_seg_vld = (note_q != '0) && (w_dur_fin != '0);
               w_end_cap = 1'b1;
            end else if (note_in != note_q) begin
               w_seg_vld = (w_dur_fin != '0);
               note_d    = note_in;
               dur_d     = '0;
            end else begin
               dur_d     = w_dur_fin;
            end
         end
         S_DRAIN: begin
            if (w_buf_free) begin
               if (mark_q) begin
                  pend_vld_d  = 1'b1;
                  pend_data_d = '1;
                  mark_d      = 1'b0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (w_seg_vld) begin
         if (w_buf_free) begin
            pend_vld_d  = 1'b1;
            pend_data_d = w_seg_word;
            if (w_cap_hit) begin
               full_d    = 1'b1;
               w_end_cap = 1'b1;
            end
         end else begin
            ovr_d = 1'b1;
         end
      end

      if (w_end_cap) begin
         state_d = S_DRAIN;
         mark_d  = c_tail_en;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         note_q      <= '0;
         dur_q       <= '0;
         pend_vld_q  <= 1'b0;
         pend_data_q <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         full_q      <= 1'b0;
         ovr_q       <= 1'b0;
         mark_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         note_q      <= note_d;
         dur_q       <= dur_d;
         pend_vld_q  <= pend_vld_d;
         pend_data_q <= pend_data_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         full_q      <= full_d;
         ovr_q       <= ovr_d;
         mark_q      <= mark_d;
      end
   end

   assign wr_en     = pend_vld_q;
   assign wr_data   = pend_data_q;
   assign wr_addr   = addr_q;
   assign length    = len_q;
   assign recording = (state_q == S_ARMED) || (state_q == S_CAPTURE);
   assign full      = full_q;
   assign overrun   = ovr_q;
   assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Write-side companion of the internal memory unit: captures live keyboard notes in record mode and packs each held note (or rest) with its quantized duration into one memory word.
- Drives the memory write port through a valid/ready handshake.
- Keeps the stored-song length, which later feeds autoplay/learning playback.
- Sits between the keyboard decoder and the internal memory unit.

Parameters:
- NOTE_W, 5, note code width; code 0 = rest.
- DUR_W, 4, duration field width in beat ticks; saturates at 2^DUR_W-1.
- DEPTH, 64, number of memory words available.
- ADDR_W, 6, address/length width (must satisfy 2^ADDR_W >= DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rec_start  in  1  one-cycle pulse; begin a new recording
- rec_stop  in  1  one-cycle pulse; end recording
- tick  in  1  one-cycle beat-time pulse (duration quantum)
- note_in  in  NOTE_W  currently pressed note, already debounced
- wr_ready  in  1  memory accepts the word this cycle
- wr_en  out  1  write-request valid
- wr_data  out  NOTE_W+DUR_W  {note, duration}
- wr_addr  out  ADDR_W  target word index
- length  out  ADDR_W+1  count of accepted words
- recording  out  1  high in ARMED or CAPTURE
- full  out  1  sticky; memory capacity reached
- overrun  out  1  sticky; a segment was dropped because a write was still pending
- done  out  1  high in DONE

Behaviour:
- Reset: all outputs 0, FSM = IDLE, pending buffer empty, any in-flight write discarded. Reset takes effect regardless of FSM state.
- FSM states: IDLE, ARMED, CAPTURE, DRAIN, DONE.

IDLE / DONE:
- rec_start clears length, wr_addr, full and overrun, then goes to ARMED.
- rec_start is ignored in ARMED, CAPTURE and DRAIN.

ARMED:
- Waits for note_in != 0; leading rests are not recorded.
- On the first nonzero note, cur_note <= note_in, dur_cnt <= 0, go to CAPTURE.
- rec_stop goes to DONE with length 0.

CAPTURE:
- Each tick increments dur_cnt, saturating at 2^DUR_W-1.
- Segment end: note_in != cur_note. The segment word is {cur_note, dur_cnt + tick}, saturated. A tick in the change cycle is credited to the ending segment.
- On segment end, cur_note <= note_in and dur_cnt <= 0.
- Segments with a final duration of 0 are dropped silently (glitch filter).
- Rests (note 0) between notes are recorded like notes.

Pending buffer and write handshake:
- A completed segment loads the one-entry pending buffer.
- wr_en rises on the next cycle, registered, so latency is 1 cycle from the note change.
- wr_en, wr_data and wr_addr are held stable until wr_en && wr_ready. On that cycle: wr_addr++, length++, buffer empty, and wr_en drops on the next cycle unless a new segment is queued.
- If a segment completes while the buffer is occupied and not accepted that cycle, the new segment is dropped and overrun <= 1.
- An acceptance and a new segment in the same cycle are both honoured; the new word goes out on the following cycle.

Capacity:
- When length + pending reaches DEPTH (or DEPTH-1 with RECORDER_TAIL_MARK_EN), no further segments are queued, full <= 1, and the FSM goes to DRAIN.

Stop:
- rec_stop in CAPTURE ends the current segment.
- It is queued only if cur_note != 0 and its duration is >= 1. Trailing rests are discarded.
- The FSM then goes to DRAIN.
- rec_stop and rec_start in the same cycle: stop wins.

DRAIN:
- Waits until the buffer is empty, then goes to DONE.
- recording = 0 and further note/tick activity is ignored.

Optional Feature:
- Macro: RECORDER_TAIL_MARK_EN.
- When defined: on leaving CAPTURE, after the last segment, the block writes an end-of-song marker word of all ones ({NOTE_W{1}, DUR_W{1}}). The marker is included in length. One slot is reserved for it: capacity ends at DEPTH-1 data words.
- When undefined: no marker is written and all DEPTH slots hold data.

Test Plan:
- Basic record:
  - Stimulus: rec_start; note_in = 3 held across 4 ticks; note_in = 7 held across 2 ticks; rec_stop; wr_ready tied 1.
  - Required response: words {3,4} @addr0 and {7,2} @addr1; length = 2; done = 1.
  - With RECORDER_TAIL_MARK_EN: additionally 0x1FF @addr2 and length = 3.
- Leading rest and glitch filter:
  - Stimulus: note_in = 0 for 5 ticks; note 9 for 1 cycle with no tick; note 5 for 3 ticks; stop.
  - Required response: the single write is {5,3}; length = 1.
- Saturation:
  - Stimulus: note 2 held for 20 ticks, then note 4 for 1 tick, then stop.
  - Required response: {2,15} then {4,1}.
- Backpressure:
  - Stimulus: wr_ready = 0 for 10 cycles while two segments complete.
  - Required response: wr_en and wr_data stay stable on the first word; the second segment is dropped; overrun = 1; after wr_ready goes high, length = 1.
- Full:
  - Stimulus: DEPTH = 4; record 6 one-tick alternating notes.
  - Required response: full = 1; length = 4 (3 plus the marker with RECORDER_TAIL_MARK_EN); done = 1; no write at addr >= 4.
- Reset mid-write:
  - Stimulus: assert rst while wr_en = 1 and wr_ready = 0.
  - Required response: next cycle wr_en = 0, length = 0, FSM IDLE; a following rec_start records normally.
